// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the processor-to-memory bridge: state encoding and
// default parameter values.
package mem_bridge_pkg;

   localparam int          DEFAULT_TIMEOUT  = 16;
   localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_ERR  = 2'd2;

endpackage

// File: rtl/mem_bridge_timer.sv
// Request watchdog: counts cycles spent waiting for an acknowledge and flags
// the cycle whose edge would take the count to TIMEOUT.
module bridge_timer
   import mem_bridge_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             W    = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);
   localparam logic [W-1:0]   TOP  = W'(TIMEOUT);

   logic [W-1:0] count;

   // Saturates at TIMEOUT so the counter can never wrap while enabled.
   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (enable && count != TOP)
         count <= count + 1'b1;
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_bridge.sv
// Bridges a processor fetch/store port onto a req/ack memory handshake, issuing
// one transaction per new {address, direction} pair with a timeout abort.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
   parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_rw,
   input  logic        cpu_sys_dne,
   output logic [31:0] instruction,
   output logic        busy,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   state_t      state;
   logic        served_valid;
   logic [31:0] served_addr;
   logic        served_rw;
   logic        trigger;
   logic        timer_clear;
   logic        timer_enable;
   logic        timer_expired;

   assign trigger = (state == ST_IDLE) && !cpu_sys_dne && !err &&
                    (!served_valid || cpu_addr != served_addr || cpu_rw != served_rw);

   assign timer_clear  = !reset || (state != ST_REQ);
   assign timer_enable = (state == ST_REQ) && !mem_ack;

   bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // The served pair is taken from the registered request, not the live CPU
   // inputs, so address changes during a transaction are not lost.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_IDLE;
         instruction  <= NOP_WORD;
         busy         <= 1'b0;
         err          <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         served_valid <= 1'b0;
         served_addr  <= '0;
         served_rw    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  state    <= ST_REQ;
                  mem_req  <= 1'b1;
                  mem_we   <= !cpu_rw;
                  mem_addr <= cpu_addr;
                  busy     <= 1'b1;
                  if (!cpu_rw)
                     mem_wdata <= cpu_wdata;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  state        <= ST_IDLE;
                  mem_req      <= 1'b0;
                  mem_we       <= 1'b0;
                  busy         <= 1'b0;
                  served_valid <= 1'b1;
                  served_addr  <= mem_addr;
                  served_rw    <= !mem_we;
                  if (!mem_we)
                     instruction <= mem_rdata;
               end else if (timer_expired) begin
                  state       <= ST_ERR;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  busy        <= 1'b0;
                  err         <= 1'b1;
                  instruction <= NOP_WORD;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles mem_req stays high without mem_ack before abort.
REQ-002 Parameter NOP_WORD, default 32'h00000000: value driven on instruction after reset or abort.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 cpu_addr  input  32  processor address (processor addr output); passed unaligned, unmodified.
REQ-006 cpu_wdata  input  32  processor write data (processor out).
REQ-007 cpu_rw  input  1  1 = read/fetch, 0 = write.
REQ-008 cpu_sys_dne  input  1  processor halted; blocks new transactions.
REQ-009 instruction  output  32  registered word fed to processor instruction input.
REQ-010 busy  output  1  transaction pending or in flight.
REQ-011 err  output  1  sticky timeout flag.
REQ-012 mem_req  output  1  memory request, held until mem_ack or timeout.
REQ-013 mem_we  output  1  1 = write cycle; valid while mem_req=1.
REQ-014 mem_addr  output  32  registered copy of cpu_addr for the transaction.
REQ-015 mem_wdata  output  32  registered copy of cpu_wdata for writes.
REQ-016 mem_rdata  input  32  read data, valid in the mem_ack cycle.
REQ-017 mem_ack  input  1  single-cycle acknowledge.

Function
REQ-018 States: IDLE, REQ, ERR; encoding lives in the shared package.
REQ-019 Trigger: IDLE, cpu_sys_dne=0, err=0, and ({cpu_addr,cpu_rw} differs from last-served pair, or first IDLE cycle after reset).
REQ-020 Trigger at edge N -> mem_req=1, mem_addr/mem_we/mem_wdata captured at edge N; busy=1 from edge N.
REQ-021 REQ: outputs stable until mem_ack=1; ack in first mem_req cycle is legal (one-cycle transaction).
REQ-022 Read ack at edge M -> instruction=mem_rdata, mem_req=0, busy=0 at edge M; served pair updated; back to IDLE.
REQ-023 Write ack -> instruction unchanged; otherwise same as REQ-022.
REQ-024 cpu_addr/cpu_rw changes during REQ ignored; new pair triggers after return to IDLE (no coalescing).
REQ-025 cpu_sys_dne=1 during REQ: in-flight transaction completes; no further trigger while high.
REQ-026 mem_ack in IDLE or ERR ignored.
REQ-027 Timeout counter starts at 0 on entry to REQ, +1 per cycle without ack; at TIMEOUT -> mem_req=0, err=1, instruction=NOP_WORD, busy=0, state ERR.
REQ-028 Ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
REQ-029 ERR absorbing until reset; no transactions issued.
REQ-030 Counter width $clog2(TIMEOUT+1); no wrap before TIMEOUT.

Reset
REQ-031 reset=0 at edge -> IDLE, instruction=NOP_WORD, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err=0, counter=0, served pair invalid.
REQ-032 Reset mid-REQ: mem_req drops at that edge; pending transaction discarded, late mem_ack ignored.
REQ-033 Reset has priority over all triggers and acks in the same cycle.

Structure
REQ-034 Package mem_bridge_pkg: state enum, default NOP_WORD constant, default TIMEOUT.
REQ-035 One sub-module, bridge_timer: clear/enable inputs, expired output, parameter TIMEOUT.

Verification
REQ-036 Reset, cpu_addr=0, rw=1, ack 2 cycles after req, mem_rdata=2B790021 -> mem_addr=0, instruction=2B790021, busy=0.
REQ-037 cpu_addr 0x4 -> 0x0EBC0E5C during REQ -> 0x4 completes first, then new req with mem_addr=0EBC0E5C.
REQ-038 rw=0, addr=54BBE901, wdata=0C270C6C, same-cycle ack -> mem_we=1 one cycle, mem_wdata=0C270C6C, instruction unchanged.
REQ-039 No ack for 16 cycles -> mem_req=0 after 16 cycles, err=1, instruction=0; later addr changes issue nothing.
REQ-040 cpu_sys_dne=1 with addr change -> mem_req stays 0; deassert -> req issued next edge.
REQ-041 reset=0 in second REQ cycle, then ack -> mem_req=0, instruction=NOP_WORD, ack ignored.
